vending_param: RTL and testbench
================================

VENDING_PARAM -- requirements
Module: vending_param

Interface
REQ-001 Parameter PRICE, default 4: item price in nickel units (4 = 20 cents); legal range 1..(2**CREDIT_W - 5).
REQ-002 Parameter CREDIT_W, default 4: width of the credit register and credit_o.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 nickle_i  input  1  nickel inserted this cycle (value 1).
REQ-006 dime_i  input  1  dime inserted this cycle (value 2).
REQ-007 quarter_i  input  1  quarter inserted this cycle (value 5).
REQ-008 cancel_i  input  1  refund request; honoured only when VEND_REFUND_EN is defined.
REQ-009 soda_o  output  1  one-cycle vend pulse.
REQ-010 chg_nickel_o  output  1  one-cycle pulse, one nickel of change or refund dispensed.
REQ-011 chg_dime_o  output  1  one-cycle pulse, one dime of change or refund dispensed.
REQ-012 credit_o  output  CREDIT_W  current credit in nickel units.
REQ-013 busy_o  output  1  high in VEND and CHANGE; coins are not accepted while it is high.
REQ-014 coin_reject_o  output  1  combinational; high in any cycle where an asserted coin input is not accepted.

Function
REQ-015 The FSM SHALL have three states: COLLECT, VEND and CHANGE; all outputs are registered except coin_reject_o.
REQ-016 In COLLECT, at most one coin SHALL be accepted per cycle, with priority nickel > dime > quarter; any other asserted coin in that cycle raises coin_reject_o.
REQ-017 An accepted coin SHALL add its value to the credit at the next edge.
REQ-018 If the sum is >= PRICE, the next state SHALL be VEND and the remainder register SHALL load (sum - PRICE); otherwise the FSM stays in COLLECT.
REQ-019 VEND SHALL last exactly one cycle with soda_o=1 and credit_o=0.
  - Next state is CHANGE if the remainder is nonzero, else COLLECT.
REQ-020 In CHANGE, one coin SHALL be dispensed per cycle: chg_dime_o when remainder >= 2 (remainder -= 2), else chg_nickel_o (remainder -= 1).
  - The FSM returns to COLLECT in the cycle after the remainder reaches 0.
REQ-021 Any coin input asserted in VEND or CHANGE SHALL be rejected (coin_reject_o=1) and SHALL NOT affect credit or the remainder.
REQ-022 Credit SHALL never exceed PRICE+4; no arithmetic wrap is permitted within the legal PRICE range.
REQ-023 A coin arriving in the same cycle as cancel_i SHALL be rejected; cancel takes precedence.
REQ-024 Latency: coin edge to soda_o is exactly 1 cycle; soda_o to first change pulse is 1 cycle.

Reset
REQ-025 While rst_ni=0, state SHALL be COLLECT, credit=0 and remainder=0; soda_o, chg_nickel_o, chg_dime_o and busy_o SHALL be 0, independent of clk_i.
REQ-026 Reset asserted in VEND or CHANGE SHALL abort the operation; undispensed change is discarded.

Configuration
REQ-027 With macro VEND_REFUND_EN defined, cancel_i in COLLECT with credit>0 SHALL:
  - move the full credit into the remainder;
  - clear the credit;
  - enter CHANGE without a soda_o pulse.
  cancel_i with credit=0 is a no-op.
REQ-028 Without VEND_REFUND_EN, cancel_i SHALL be ignored, and no refund logic is synthesised.

Verification (PRICE=4, CREDIT_W=4)
REQ-029 quarter_i from credit 0 -> soda_o at cycle +1, chg_nickel_o at cycle +2, busy_o low at cycle +3.
REQ-030 dime, dime on consecutive cycles -> credit_o 2, then soda_o; no change pulses; back to COLLECT.
REQ-031 dime then quarter -> credit 7 -> soda_o, then chg_dime_o, then chg_nickel_o (remainder 3).
REQ-032 nickle_i and quarter_i in the same cycle -> nickel accepted (credit 1), coin_reject_o=1; a dime during the VEND cycle -> rejected, credit unaffected.
REQ-033 (VEND_REFUND_EN) credit 3, then cancel_i -> chg_dime_o, chg_nickel_o, no soda_o, credit_o 0.
REQ-034 rst_ni low during CHANGE with remainder 3 -> outputs 0 immediately; after release, state is COLLECT with credit 0.

Source files
------------

// File: rtl/vending_param_if.sv
// Vending machine bus: coin/cancel inputs and vend/change/credit outputs.
// The customer side (coin mechanism, bench) drives the master modport;
// the vending controller uses the slave modport.
interface vending_param_if #(
  parameter int CREDIT_W = 4
);
  logic                nickle_i;
  logic                dime_i;
  logic                quarter_i;
  logic                cancel_i;
  logic                soda_o;
  logic                chg_nickel_o;
  logic                chg_dime_o;
  logic [CREDIT_W-1:0] credit_o;
  logic                busy_o;
  logic                coin_reject_o;

  modport master (
    output nickle_i, dime_i, quarter_i, cancel_i,
    input  soda_o, chg_nickel_o, chg_dime_o, credit_o, busy_o, coin_reject_o
  );

  modport slave (
    input  nickle_i, dime_i, quarter_i, cancel_i,
    output soda_o, chg_nickel_o, chg_dime_o, credit_o, busy_o, coin_reject_o
  );
endinterface

// File: rtl/vending_param.sv
// Parameterised vending controller: collects nickels/dimes/quarters,
// vends once credit reaches PRICE, then pays change one coin per cycle
// (dimes first). All outputs are registered except coin_reject_o.
// Optional refund on cancel_i is enabled by defining VEND_REFUND_EN.
module vending_param #(
  parameter int PRICE    = 4,
  parameter int CREDIT_W = 4
) (
  input logic            clk_i,
  input logic            rst_ni,
  vending_param_if.slave bus
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_VEND    = 2'd1;
  localparam logic [1:0] S_CHANGE  = 2'd2;

  localparam logic [CREDIT_W-1:0] L_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] L_ZERO  = '0;
  localparam logic [CREDIT_W-1:0] L_ONE   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] L_TWO   = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] L_FIVE  = CREDIT_W'(5);

  logic [1:0]          r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_rem;
  logic                r_soda;
  logic                r_chg_nickel;
  logic                r_chg_dime;
  logic                r_busy;

  logic                w_cancel;
  logic [2:0]          w_coins;
  logic [2:0]          w_accept;
  logic [CREDIT_W-1:0] w_value;
  logic [CREDIT_W-1:0] w_sum;
  logic [1:0]          w_state_nx;
  logic [CREDIT_W-1:0] w_credit_nx;
  logic [CREDIT_W-1:0] w_rem_nx;
  logic                w_soda_nx;
  logic                w_chg_nickel_nx;
  logic                w_chg_dime_nx;

`ifdef VEND_REFUND_EN
  assign w_cancel = bus.cancel_i;
`else
  // Cancel is ignored in this build; the input is kept only for port compatibility.
  logic w_unused_cancel;
  assign w_unused_cancel = bus.cancel_i;
  assign w_cancel        = 1'b0;
`endif

  assign w_coins = {bus.quarter_i, bus.dime_i, bus.nickle_i};

  // Coin acceptance: only in COLLECT, never alongside an honoured cancel,
  // one coin per cycle with nickel > dime > quarter priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_accept = 3'b000;
    w_value  = L_ZERO;
    if (r_state == S_COLLECT && !w_cancel) begin
      if (w_coins[0]) begin
        w_accept = 3'b001;
        w_value  = L_ONE;
      end else if (w_coins[1]) begin
        w_accept = 3'b010;
        w_value  = L_TWO;
      end else if (w_coins[2]) begin
        w_accept = 3'b100;
        w_value  = L_FIVE;
      end
    end
  end

  // Credit is below PRICE in COLLECT, so the sum peaks at PRICE+4 and never wraps.
  assign w_sum = r_credit + w_value;

  assign bus.coin_reject_o = |(w_coins & ~w_accept);

  // Next-state and next-output decisions; a change coin is issued on the
  // same edge that enters or stays in CHANGE, so each CHANGE cycle shows one pulse.
  always_comb begin
    w_state_nx      = r_state;
    w_credit_nx     = r_credit;
    w_rem_nx        = r_rem;
    w_soda_nx       = 1'b0;
    w_chg_nickel_nx = 1'b0;
    w_chg_dime_nx   = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (w_cancel && r_credit != L_ZERO) begin
          // Refund: the whole credit becomes change, first coin goes out now.
          w_credit_nx     = L_ZERO;
          w_state_nx      = S_CHANGE;
          w_chg_dime_nx   = (r_credit >= L_TWO);
          w_chg_nickel_nx = (r_credit <  L_TWO);
          w_rem_nx        = r_credit - ((r_credit >= L_TWO) ? L_TWO : L_ONE);
        end else if (w_accept != 3'b000) begin
          if (w_sum >= L_PRICE) begin
            w_state_nx  = S_VEND;
            w_credit_nx = L_ZERO;
            w_rem_nx    = w_sum - L_PRICE;
            w_soda_nx   = 1'b1;
          end else begin
            w_credit_nx = w_sum;
          end
        end
      end
      S_VEND, S_CHANGE: begin
        if (r_rem != L_ZERO) begin
          w_state_nx      = S_CHANGE;
          w_chg_dime_nx   = (r_rem >= L_TWO);
          w_chg_nickel_nx = (r_rem <  L_TWO);
          w_rem_nx        = r_rem - ((r_rem >= L_TWO) ? L_TWO : L_ONE);
        end else begin
          w_state_nx = S_COLLECT;
        end
      end
      default: begin
        w_state_nx  = S_COLLECT;
        w_credit_nx = L_ZERO;
        w_rem_nx    = L_ZERO;
      end
    endcase
  end

  // State and registered outputs; reset aborts any vend and drops pending change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_COLLECT;
      r_credit     <= L_ZERO;
      r_rem        <= L_ZERO;
      r_soda       <= 1'b0;
      r_chg_nickel <= 1'b0;
      r_chg_dime   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state      <= w_state_nx;
      r_credit     <= w_credit_nx;
      r_rem        <= w_rem_nx;
      r_soda       <= w_soda_nx;
      r_chg_nickel <= w_chg_nickel_nx;
      r_chg_dime   <= w_chg_dime_nx;
      r_busy       <= (w_state_nx != S_COLLECT);
    end
  end

  assign bus.soda_o       = r_soda;
  assign bus.chg_nickel_o = r_chg_nickel;
  assign bus.chg_dime_o   = r_chg_dime;
  assign bus.credit_o     = r_credit;
  assign bus.busy_o       = r_busy;

endmodule

// File: tb/tb_vending_param.sv
// Self-checking bench for vending_param (PRICE=4, CREDIT_W=4): directed
// vector table, hand-written reset/refund sequences, then random coins
// checked against a queue-based behavioural model.
module tb_vending_param;

  localparam int PRICE    = 4;
  localparam int CREDIT_W = 4;
`ifdef VEND_REFUND_EN
  localparam bit REFUND = 1'b1;
`else
  localparam bit REFUND = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  vending_param_if #(.CREDIT_W(CREDIT_W)) bus ();

  vending_param #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic n, d, q, c;
    logic rej, soda, cn, cd, busy;
    int   credit;
  } vec_t;

  typedef struct {
    logic soda, cn, cd, busy;
    int   credit;
  } obs_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic run_cycle(input logic n, d, q, c,
                           input logic e_rej, e_soda, e_cn, e_cd, e_busy,
                           input int e_credit, input string tag);
    @(negedge clk);
    bus.nickle_i  = n;
    bus.dime_i    = d;
    bus.quarter_i = q;
    bus.cancel_i  = c;
    #1;
    check({tag, " reject"}, int'(bus.coin_reject_o), int'(e_rej));
    @(posedge clk);
    #1;
    check({tag, " soda"},   int'(bus.soda_o),       int'(e_soda));
    check({tag, " chg_n"},  int'(bus.chg_nickel_o), int'(e_cn));
    check({tag, " chg_d"},  int'(bus.chg_dime_o),   int'(e_cd));
    check({tag, " busy"},   int'(bus.busy_o),       int'(e_busy));
    check({tag, " credit"}, int'(bus.credit_o),     e_credit);
  endtask

  // ---------------- behavioural model ----------------
  obs_t m_cur;
  obs_t m_sched[$];
  int   m_credit;

  function automatic obs_t mk(input logic soda, cn, cd, busy, input int credit);
    obs_t o;
    o.soda = soda; o.cn = cn; o.cd = cd; o.busy = busy; o.credit = credit;
    return o;
  endfunction

  function automatic void model_reset();
    m_credit = 0;
    m_sched.delete();
    m_cur = mk(0, 0, 0, 0, 0);
  endfunction

  // Greedy change: as many dimes as fit, then at most one nickel.
  function automatic void schedule_change(input int amount);
    for (int i = 0; i < amount / 2; i++) m_sched.push_back(mk(0, 0, 1, 1, 0));
    if (amount % 2 == 1) m_sched.push_back(mk(0, 1, 0, 1, 0));
  endfunction

  function automatic logic model_reject(input logic n, d, q, c);
    int cnt;
    cnt = int'(n) + int'(d) + int'(q);
    if (cnt == 0) return 1'b0;
    if (m_cur.busy) return 1'b1;
    if (REFUND && c) return 1'b1;
    return cnt > 1;
  endfunction

  function automatic void model_step(input logic n, d, q, c);
    int v;
    if (m_cur.busy) begin
      if (m_sched.size() > 0) m_cur = m_sched.pop_front();
      else m_cur = mk(0, 0, 0, 0, m_credit);
      return;
    end
    if (REFUND && c) begin
      if (m_credit > 0) begin
        schedule_change(m_credit);
        m_credit = 0;
        m_cur = m_sched.pop_front();
      end else begin
        m_cur = mk(0, 0, 0, 0, m_credit);
      end
      return;
    end
    v = n ? 1 : d ? 2 : q ? 5 : 0;
    m_credit += v;
    if (m_credit >= PRICE) begin
      schedule_change(m_credit - PRICE);
      m_credit = 0;
      m_cur = mk(1, 0, 0, 1, 0);
    end else begin
      m_cur = mk(0, 0, 0, 0, m_credit);
    end
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.nickle_i = 0; bus.dime_i = 0; bus.quarter_i = 0; bus.cancel_i = 0;
    rst_n = 1'b0;
    #1;
    check({tag, " rst soda"},   int'(bus.soda_o),       0);
    check({tag, " rst chg_n"},  int'(bus.chg_nickel_o), 0);
    check({tag, " rst chg_d"},  int'(bus.chg_dime_o),   0);
    check({tag, " rst busy"},   int'(bus.busy_o),       0);
    check({tag, " rst credit"}, int'(bus.credit_o),     0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t vecs[$];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.nickle_i = 0; bus.dime_i = 0; bus.quarter_i = 0; bus.cancel_i = 0;
    model_reset();

    //            n  d  q  c  rej soda cn cd busy credit
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1, 0}); // quarter -> vend
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1, 0}); // nickel change
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0}); // idle again
    vecs.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2}); // dime
    vecs.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1, 0}); // dime -> vend
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0}); // no change
    vecs.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2}); // dime
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1, 0}); // quarter, 7 -> vend
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1, 0}); // dime change
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1, 0}); // nickel change
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0}); // collect
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1}); // nickel wins, quarter rejected
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1, 0}); // 6 -> vend, rem 2
    vecs.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1, 0}); // dime in VEND rejected
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0}); // credit untouched
    vecs.push_back('{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1}); // nickel
    vecs.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 3}); // dime, credit 3
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1, 0}); // 8 = PRICE+4
    vecs.push_back('{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1, 0}); // dime change, coin rejected
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1, 0}); // second dime
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0}); // collect

    #12;
    check("reset soda",   int'(bus.soda_o),   0);
    check("reset busy",   int'(bus.busy_o),   0);
    check("reset credit", int'(bus.credit_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_cycle(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].c,
                vecs[i].rej, vecs[i].soda, vecs[i].cn, vecs[i].cd, vecs[i].busy,
                vecs[i].credit, $sformatf("vec%0d", i));
    end

    // Reset in the middle of CHANGE with remainder 3: change is discarded.
    run_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, "rstseq dime");
    run_cycle(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, "rstseq quarter");
    run_cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, "rstseq chg_d");
    do_reset("rstseq");
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rstseq after");
    run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rstseq nickel");
    do_reset("pre-cancel");

    // Cancel handling.
    run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "cancel nickel");
    run_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 3, "cancel dime");
`ifdef VEND_REFUND_EN
    run_cycle(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, "refund dime");
    run_cycle(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "refund nickel");
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "refund done");
    run_cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "refund zero noop");
    run_cycle(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, "refund coin+cancel");
`else
    run_cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 3, "cancel ignored");
    run_cycle(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, "cancel coin accepted");
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "cancel done");
`endif

    // Random traffic against the behavioural model.
    do_reset("rand start");
    for (int i = 0; i < 3000; i++) begin
      logic n, d, q, c, e_rej;
      if ($urandom_range(0, 299) == 0) begin
        do_reset($sformatf("rand%0d", i));
      end else begin
        n = ($urandom_range(0, 4) == 0);
        d = ($urandom_range(0, 4) == 0);
        q = ($urandom_range(0, 5) == 0);
        c = ($urandom_range(0, 11) == 0);
        e_rej = model_reject(n, d, q, c);
        model_step(n, d, q, c);
        run_cycle(n, d, q, c, e_rej, m_cur.soda, m_cur.cn, m_cur.cd, m_cur.busy,
                  m_cur.credit, $sformatf("rand%0d", i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
